// File: rtl/skin_cfg_pkg.sv
// Shared definitions for the skin-detection configuration path: register
// map, controller states, default thresholds and the window sanity rule.
package skin_cfg_pkg;

  localparam logic [2:0] ADDR_CB_LO = 3'd0;
  localparam logic [2:0] ADDR_CB_HI = 3'd1;
  localparam logic [2:0] ADDR_CR_LO = 3'd2;
  localparam logic [2:0] ADDR_CR_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL  = 3'd4;

  // Default exclusive Cb/Cr window, also used by the detection pipeline.
  localparam logic [7:0] CB_LO_DEF = 8'd77;
  localparam logic [7:0] CB_HI_DEF = 8'd127;
  localparam logic [7:0] CR_LO_DEF = 8'd133;
  localparam logic [7:0] CR_HI_DEF = 8'd173;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    APPLY
  } cfg_state_t;

  typedef struct packed {
    logic [7:0] cb_lo;
    logic [7:0] cb_hi;
    logic [7:0] cr_lo;
    logic [7:0] cr_hi;
    logic       en;
  } thr_set_t;

  // A window is usable only if both lower bounds sit strictly below the uppers.
  function automatic logic window_ok(input thr_set_t s);
    return (s.cb_lo < s.cb_hi) && (s.cr_lo < s.cr_hi);
  endfunction

endpackage

// File: rtl/skin_frame_stat.sv
// Frame statistics: vsync edge detection, saturating per-frame skin-pixel
// counter and the end-of-frame report registers.
module skin_frame_stat #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_in,
  input  logic             href_in,
  input  logic             clken_in,
  input  logic             mask_in,
  output logic             fall,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             frame_cnt_valid,
  output logic [15:0]      frame_id
);

  logic             vsync_d;
  logic             rise;
  logic             hit;
  logic             frame_armed;
  logic [CNT_W-1:0] cnt;

  assign fall = ~vsync_in & vsync_d;
  assign rise = vsync_in & ~vsync_d;
  assign hit  = clken_in & href_in & mask_in;

  // Delayed vsync for edge detection.
  // NOTE: clocked state uses <= so every flop samples pre-edge values,
  // independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_d <= 1'b0;
    else        vsync_d <= vsync_in;
  end

  // Per-frame counter: cleared at frame start, stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (fall)              cnt <= '0;
    else if (hit && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

  // Arms reporting once a real frame start has been seen after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    frame_armed <= 1'b0;
    else if (fall) frame_armed <= 1'b1;
  end

  // Report the finished frame's total at frame end, if that frame was whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt       <= '0;
      frame_cnt_valid <= 1'b0;
      frame_id        <= 16'd0;
    end else begin
      frame_cnt_valid <= 1'b0;
      if (rise && frame_armed) begin
        frame_cnt       <= cnt;
        frame_cnt_valid <= 1'b1;
        frame_id        <= frame_id + 16'd1;
      end
    end
  end

endmodule

// File: rtl/skin_thresh_cfg_ctrl.sv
// Skin-detection configuration controller: host-written shadow thresholds,
// commit handshake that applies the set only at a frame start, and the
// per-frame skin-pixel statistics.
module skin_thresh_cfg_ctrl
  import skin_cfg_pkg::*;
#(
  parameter int         CNT_W     = 19,
  parameter logic [7:0] CB_LO_RST = CB_LO_DEF,
  parameter logic [7:0] CB_HI_RST = CB_HI_DEF,
  parameter logic [7:0] CR_LO_RST = CR_LO_DEF,
  parameter logic [7:0] CR_HI_RST = CR_HI_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr_valid,
  output logic             cfg_wr_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic             cfg_commit,
  output logic             cfg_pending,
  output logic             cfg_reject,
  input  logic             vsync_in,
  input  logic             href_in,
  input  logic             clken_in,
  input  logic             mask_in,
  output logic [7:0]       thr_cb_lo,
  output logic [7:0]       thr_cb_hi,
  output logic [7:0]       thr_cr_lo,
  output logic [7:0]       thr_cr_hi,
  output logic             det_en,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             frame_cnt_valid,
  output logic [15:0]      frame_id
);

  localparam thr_set_t RST_SET = '{
    cb_lo: CB_LO_RST, cb_hi: CB_HI_RST,
    cr_lo: CR_LO_RST, cr_hi: CR_HI_RST, en: 1'b1
  };

  cfg_state_t state, state_nxt;
  thr_set_t   shadow, shadow_nxt, active;
  logic       wr_fire, apply, reject_nxt, fall;

  assign cfg_wr_ready = (state == IDLE);
  assign cfg_pending  = (state == PEND);
  assign wr_fire      = cfg_wr_valid & cfg_wr_ready;

  // Shadow set as it will be after this cycle's accepted write.
  // NOTE: assigning the default first means every path writes shadow_nxt,
  // so no latch is inferred for the unhandled addresses.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_fire) begin
      case (cfg_addr)
        ADDR_CB_LO: shadow_nxt.cb_lo = cfg_wdata;
        ADDR_CB_HI: shadow_nxt.cb_hi = cfg_wdata;
        ADDR_CR_LO: shadow_nxt.cr_lo = cfg_wdata;
        ADDR_CR_HI: shadow_nxt.cr_hi = cfg_wdata;
        ADDR_CTRL:  shadow_nxt.en    = cfg_wdata[0];
        default:    ;
      endcase
    end
  end

  // Commit FSM: validate, wait for frame start, then copy shadow to active.
  always_comb begin
    state_nxt  = state;
    apply      = 1'b0;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_commit) begin
          if (window_ok(shadow_nxt)) state_nxt  = PEND;
          else                       reject_nxt = 1'b1;
        end
      end
      PEND:    if (fall) state_nxt = APPLY;
      APPLY: begin
        apply     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shadow and active sets.
  // NOTE: these are a handful of flops, not a RAM, so both are reset to the
  // defaults and the pipeline never sees an undefined window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= RST_SET;
      active <= RST_SET;
    end else begin
      shadow <= shadow_nxt;
      if (apply) active <= shadow;
    end
  end

  // One-cycle reject pulse for a commit with an empty window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_reject <= 1'b0;
    else        cfg_reject <= reject_nxt;
  end

  assign thr_cb_lo = active.cb_lo;
  assign thr_cb_hi = active.cb_hi;
  assign thr_cr_lo = active.cr_lo;
  assign thr_cr_hi = active.cr_hi;
  assign det_en    = active.en;

  skin_frame_stat #(.CNT_W(CNT_W)) u_stat (
    .clk             (clk),
    .rst_n           (rst_n),
    .vsync_in        (vsync_in),
    .href_in         (href_in),
    .clken_in        (clken_in),
    .mask_in         (mask_in),
    .fall            (fall),
    .frame_cnt       (frame_cnt),
    .frame_cnt_valid (frame_cnt_valid),
    .frame_id        (frame_id)
  );

endmodule
